frame_arb: RTL and testbench

FRAME_ARB -- requirements
Module: frame_arb

---
 rtl/mc_pkg.sv | 26 ++
 rtl/frame_arb_pick.sv | 19 +
 rtl/frame_arb.sv | 102 ++++++++++
 tb/tb_frame_arb.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared frame field layout, arbiter FSM states and priority policy encodings
package mc_pkg;
    // Flag positions counted down from the frame MSB: flag bit = W - offset
    typedef enum int {
        FLD_RW_OFS  = 1,
        FLD_SOF_OFS = 2,
        FLD_EOF_OFS = 3
    } frame_fld_e;
    // Widths of the fields below the flags: col, row, then data in the low bits
    typedef enum int {
        FLD_COL_W  = 6,
        FLD_ROW_W  = 16,
        FLD_DATA_W = 64
    } frame_wid_e;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GNT_WR = 2'd1,
        ST_GNT_RD = 2'd2
    } arb_state_e;
    typedef enum logic [1:0] {
        PRIO_RR       = 2'd0,
        PRIO_WR_FIRST = 2'd1,
        PRIO_RD_FIRST = 2'd2,
        PRIO_RR_ALT   = 2'd3
    } arb_prio_e;
endpackage

// File: rtl/frame_arb_pick.sv
// frame_arb_pick: combinational winner selection between the write and read requesters
module frame_arb_pick
    import mc_pkg::*;
(
    input  logic       wr_valid_i,
    input  logic       rd_valid_i,
    input  logic [1:0] prio_i,
    input  logic       last_rd_i,
    input  logic       force_i,
    output logic       pick_wr_o
);
    // A lone requester wins; under contention a starvation force beats the policy, and round-robin favours the side not served last
    always_comb begin
        pick_wr_o = !(wr_valid_i && rd_valid_i) ? wr_valid_i :
                    force_i                     ? last_rd_i  :
                    prio_i == PRIO_WR_FIRST     ? 1'b1       :
                    prio_i == PRIO_RD_FIRST     ? 1'b0       : last_rd_i;
    end
endmodule

// File: rtl/frame_arb.sv
// frame_arb: burst-locked write/read frame arbiter; ARB_STARVE_GUARD_EN adds a starvation guard
module frame_arb
    import mc_pkg::*;
#(
    parameter int ARRAY_FRAME_DATA_WIDTH = 89,
    parameter int STARVE_LIMIT           = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              mc_en,
    input  logic [1:0]                        axi_rw_prio,
    input  logic                              wr_frame_valid,
    output logic                              wr_frame_ready,
    input  logic [ARRAY_FRAME_DATA_WIDTH-1:0] wr_frame_data,
    input  logic                              rd_frame_valid,
    output logic                              rd_frame_ready,
    input  logic [ARRAY_FRAME_DATA_WIDTH-1:0] rd_frame_data,
    output logic                              axi2array_frame_valid,
    input  logic                              axi2array_frame_ready,
    output logic [ARRAY_FRAME_DATA_WIDTH-1:0] axi2array_frame_data,
    output logic [1:0]                        arb_grant
);
    localparam int EOF_BIT = ARRAY_FRAME_DATA_WIDTH - int'(FLD_EOF_OFS);
    arb_state_e state_q;
    logic [1:0] grant_q;
    logic       last_rd_q;
    logic       pick_wr, starve_force, decide, wr_sel, rd_sel, wr_last, rd_last;
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
        $error("STARVE_LIMIT must fit the 3-bit starvation counter (1..7)");
    end
    assign decide  = state_q == ST_IDLE && mc_en && (wr_frame_valid || rd_frame_valid);
    assign wr_sel  = state_q == ST_GNT_WR;
    assign rd_sel  = state_q == ST_GNT_RD;
    assign wr_last = wr_frame_valid && axi2array_frame_ready && wr_frame_data[EOF_BIT];
    assign rd_last = rd_frame_valid && axi2array_frame_ready && rd_frame_data[EOF_BIT];
    assign arb_grant = grant_q;
    frame_arb_pick u_pick (
        .wr_valid_i (wr_frame_valid),
        .rd_valid_i (rd_frame_valid),
        .prio_i     (axi_rw_prio),
        .last_rd_i  (last_rd_q),
        .force_i    (starve_force),
        .pick_wr_o  (pick_wr)
    );
`ifdef ARB_STARVE_GUARD_EN
    logic [2:0] cnt_q, cnt_d;
    logic       other_valid;
    assign starve_force = cnt_q == 3'(STARVE_LIMIT);
    assign other_valid  = pick_wr ? rd_frame_valid : wr_frame_valid;
    // Count back-to-back bursts to one side that kept the other waiting; an idle rival or a forced switch restarts the count
    always_comb begin
        cnt_d = cnt_q;
        if (decide)
            cnt_d = (!other_valid || starve_force) ? 3'd0 :
                    (pick_wr != last_rd_q)         ? cnt_q + 3'd1 : 3'd1;
    end
    // Starvation counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= 3'd0;
        else
            cnt_q <= cnt_d;
    end
`else
    assign starve_force = 1'b0;
`endif
    // Granted requester passes straight through to the array side; idle drives everything low
    always_comb begin
        axi2array_frame_valid = wr_sel ? wr_frame_valid : rd_sel ? rd_frame_valid : 1'b0;
        axi2array_frame_data  = wr_sel ? wr_frame_data  : rd_sel ? rd_frame_data  : '0;
        wr_frame_ready        = wr_sel && axi2array_frame_ready;
        rd_frame_ready        = rd_sel && axi2array_frame_ready;
    end
    // Arbitration FSM: decide in IDLE, hold the grant until an eof frame handshakes, then one idle bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= 2'b00;
            last_rd_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: if (decide) begin
                    state_q   <= pick_wr ? ST_GNT_WR : ST_GNT_RD;
                    grant_q   <= pick_wr ? 2'b01 : 2'b10;
                    last_rd_q <= !pick_wr;
                end
                ST_GNT_WR: if (wr_last) begin
                    state_q <= ST_IDLE;
                    grant_q <= 2'b00;
                end
                ST_GNT_RD: if (rd_last) begin
                    state_q <= ST_IDLE;
                    grant_q <= 2'b00;
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_frame_arb.sv
// tb_frame_arb: directed and randomized checks of frame_arb against a burst-level arbitration model
module tb_frame_arb;
    localparam int W   = 89;
    localparam int LIM = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         mc_en = 1'b0;
    logic [1:0]   prio = 2'd0;
    logic         wr_frame_valid = 1'b0, rd_frame_valid = 1'b0, axi2array_frame_ready = 1'b0;
    logic [W-1:0] wr_frame_data = '0, rd_frame_data = '0;
    logic         wr_frame_ready, rd_frame_ready, axi2array_frame_valid;
    logic [W-1:0] axi2array_frame_data;
    logic [1:0]   arb_grant;
    int           vectors = 0, errors = 0, cyc = 0, rdy_pct = 100;
    logic [W-1:0] wq[$], rq[$], mw[$], mr[$], exp_d[$], obs_d[$];
    logic [1:0]   exp_g[$], obs_g[$], gnt_hist[$];
    int           obs_t[$];
    bit           rdy_pat[$];
    bit           m_last_rd;
    int           m_run;

    always #5 clk = ~clk;

    frame_arb #(.ARRAY_FRAME_DATA_WIDTH(W), .STARVE_LIMIT(LIM)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .mc_en                 (mc_en),
        .axi_rw_prio           (prio),
        .wr_frame_valid        (wr_frame_valid),
        .wr_frame_ready        (wr_frame_ready),
        .wr_frame_data         (wr_frame_data),
        .rd_frame_valid        (rd_frame_valid),
        .rd_frame_ready        (rd_frame_ready),
        .rd_frame_data         (rd_frame_data),
        .axi2array_frame_valid (axi2array_frame_valid),
        .axi2array_frame_ready (axi2array_frame_ready),
        .axi2array_frame_data  (axi2array_frame_data),
        .arb_grant             (arb_grant)
    );

    function automatic logic [W-1:0] mk(input bit is_wr, input bit sof, input bit eof);
        logic [W-1:0] f;
        f = W'({$urandom(), $urandom(), $urandom()});
        f[W-1] = is_wr;
        f[W-2] = sof;
        f[W-3] = eof;
        return f;
    endfunction

    task automatic add_burst(input bit is_wr, input int len, input bit sof);
        for (int i = 0; i < len; i++)
            if (is_wr) wq.push_back(mk(1'b1, sof && i == 0, i == len - 1));
            else       rq.push_back(mk(1'b0, sof && i == 0, i == len - 1));
    endtask

    // Reference: replay the pending bursts one whole burst at a time under the arbitration rules
    task automatic model_run();
        bit pick_w, both, forced;
        logic [W-1:0] f;
        mw = wq;
        mr = rq;
        while (mw.size() > 0 || mr.size() > 0) begin
            both   = mw.size() > 0 && mr.size() > 0;
            forced = GUARD && both && m_run >= LIM;
            if (!both)              pick_w = mw.size() > 0;
            else if (forced)        pick_w = m_last_rd;
            else if (prio == 2'd1)  pick_w = 1'b1;
            else if (prio == 2'd2)  pick_w = 1'b0;
            else                    pick_w = m_last_rd;
            if (!both || forced)            m_run = 0;
            else if (pick_w == !m_last_rd)  m_run = m_run + 1;
            else                            m_run = 1;
            m_last_rd = !pick_w;
            do begin
                f = pick_w ? mw.pop_front() : mr.pop_front();
                exp_d.push_back(f);
                exp_g.push_back(pick_w ? 2'b01 : 2'b10);
            end while (!f[W-3]);
        end
    endtask

    task automatic drive();
        wr_frame_valid = wq.size() > 0;
        wr_frame_data  = wq.size() > 0 ? wq[0] : '0;
        rd_frame_valid = rq.size() > 0;
        rd_frame_data  = rq.size() > 0 ? rq[0] : '0;
    endtask

    // One cycle: drive at negedge, check the pass-through path, log array-side handshakes
    task automatic step();
        logic         ev, ewr, erd;
        logic [W-1:0] ed;
        @(negedge clk);
        drive();
        axi2array_frame_ready = rdy_pat.size() > 0 ? rdy_pat.pop_front() : ($urandom_range(0, 99) < rdy_pct);
        #1;
        ev  = arb_grant == 2'b01 ? wr_frame_valid : arb_grant == 2'b10 ? rd_frame_valid : 1'b0;
        ed  = arb_grant == 2'b01 ? wr_frame_data  : arb_grant == 2'b10 ? rd_frame_data  : '0;
        ewr = arb_grant == 2'b01 && axi2array_frame_ready;
        erd = arb_grant == 2'b10 && axi2array_frame_ready;
        vectors++;
        if (!(arb_grant inside {2'b00, 2'b01, 2'b10}) ||
            {axi2array_frame_valid, axi2array_frame_data, wr_frame_ready, rd_frame_ready} !== {ev, ed, ewr, erd}) begin
            errors++;
            $display("FAIL passthru cyc=%0d gnt=%b got v=%b wr_rdy=%b rd_rdy=%b want v=%b wr_rdy=%b rd_rdy=%b",
                     cyc, arb_grant, axi2array_frame_valid, wr_frame_ready, rd_frame_ready, ev, ewr, erd);
        end
        gnt_hist.push_back(arb_grant);
        if (axi2array_frame_valid && axi2array_frame_ready) begin
            obs_d.push_back(axi2array_frame_data);
            obs_g.push_back(arb_grant);
            obs_t.push_back(cyc);
        end
        if (wr_frame_valid && wr_frame_ready) void'(wq.pop_front());
        if (rd_frame_valid && rd_frame_ready) void'(rq.pop_front());
        @(posedge clk);
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((wq.size() > 0 || rq.size() > 0) && n < budget) begin
            step();
            n++;
        end
        vectors++;
        if (wq.size() > 0 || rq.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout got wr=%0d rd=%0d frames left want 0", wq.size(), rq.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mc_en = 1'b1;
        wr_frame_valid = 1'b0;
        rd_frame_valid = 1'b0;
        wr_frame_data = '0;
        rd_frame_data = '0;
        axi2array_frame_ready = 1'b0;
        rdy_pct = 100;
        wq.delete(); rq.delete(); obs_d.delete(); obs_g.delete(); obs_t.delete();
        exp_d.delete(); exp_g.delete(); gnt_hist.delete(); rdy_pat.delete();
        m_last_rd = 1'b1;
        m_run = 0;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        mc_en = 1'b1;
        wr_frame_valid = 1'b1;
        rd_frame_valid = 1'b1;
        wr_frame_data = mk(1'b1, 1'b1, 1'b1);
        rd_frame_data = mk(1'b0, 1'b1, 1'b1);
        axi2array_frame_ready = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (arb_grant !== 2'b00) begin errors++; $display("FAIL rst_grant got %b want 00", arb_grant); end
        vectors++;
        if (axi2array_frame_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", axi2array_frame_valid); end
        vectors++;
        if (axi2array_frame_data !== '0) begin errors++; $display("FAIL rst_data got %h want 0", axi2array_frame_data); end
        vectors++;
        if (wr_frame_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready got %b want 0", wr_frame_ready); end
        vectors++;
        if (rd_frame_ready !== 1'b0) begin errors++; $display("FAIL rst_rd_ready got %b want 0", rd_frame_ready); end
        do_reset();
    endtask

    task automatic test_write_first();
        int exp_t[5];
        exp_t = '{1, 2, 3, 4, 6};
        do_reset();
        prio = 2'd1;
        add_burst(1'b1, 4, 1'b1);
        add_burst(1'b0, 1, 1'b1);
        model_run();
        drain(50);
        vectors++;
        if (obs_t.size() != 5) begin errors++; $display("FAIL wf_count got %0d frames want 5", obs_t.size()); end
        for (int i = 0; i < 5 && i < obs_t.size(); i++) begin
            vectors++;
            if (obs_t[i] != exp_t[i] || obs_g[i] !== exp_g[i] || obs_d[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL wf_frame%0d got cyc=%0d gnt=%b data=%h want cyc=%0d gnt=%b data=%h",
                         i, obs_t[i], obs_g[i], obs_d[i], exp_t[i], exp_g[i], exp_d[i]);
            end
        end
        vectors++;
        if (gnt_hist.size() < 6 || gnt_hist[5] !== 2'b00) begin errors++; $display("FAIL wf_bubble got gnt=%b want 00", gnt_hist.size() > 5 ? gnt_hist[5] : 2'bxx); end
    endtask

    task automatic test_round_robin();
        logic [1:0] want;
        for (int p = 0; p < 4; p += 3) begin
            do_reset();
            prio = 2'(p);
            for (int k = 0; k < 4; k++) begin
                add_burst(1'b1, 1, 1'b1);
                add_burst(1'b0, 1, 1'b1);
            end
            model_run();
            drain(100);
            vectors++;
            if (obs_d.size() != exp_d.size()) begin errors++; $display("FAIL rr_count got %0d frames want %0d", obs_d.size(), exp_d.size()); end
            foreach (exp_d[i]) if (i < obs_d.size()) begin
                want = (i % 2 == 0) ? 2'b01 : 2'b10;
                vectors++;
                if (obs_g[i] !== want || obs_d[i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL rr_p%0d_frame%0d got gnt=%b data=%h want gnt=%b data=%h", p, i, obs_g[i], obs_d[i], want, exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_ready_toggle();
        do_reset();
        prio = 2'd0;
        rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        add_burst(1'b1, 4, 1'b1);
        add_burst(1'b0, 2, 1'b0);
        model_run();
        drain(60);
        vectors++;
        if (obs_d.size() != exp_d.size()) begin errors++; $display("FAIL tog_count got %0d frames want %0d", obs_d.size(), exp_d.size()); end
        foreach (exp_d[i]) if (i < obs_d.size()) begin
            vectors++;
            if (obs_g[i] !== exp_g[i] || obs_d[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL tog_frame%0d got gnt=%b data=%h want gnt=%b data=%h", i, obs_g[i], obs_d[i], exp_g[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        prio = 2'd0;
        add_burst(1'b1, 4, 1'b1);
        add_burst(1'b0, 1, 1'b1);
        step();
        step();
        @(negedge clk);
        drive();
        axi2array_frame_ready = 1'b1;
        #1;
        vectors++;
        if (arb_grant !== 2'b01 || axi2array_frame_valid !== 1'b1 || axi2array_frame_data !== wq[0]) begin
            errors++;
            $display("FAIL mid_frame2 got gnt=%b v=%b want gnt=01 v=1", arb_grant, axi2array_frame_valid);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({arb_grant, axi2array_frame_valid, wr_frame_ready, rd_frame_ready} !== 5'b0 || axi2array_frame_data !== '0) begin
            errors++;
            $display("FAIL mid_rst got gnt=%b v=%b wr_rdy=%b rd_rdy=%b data=%h want all 0",
                     arb_grant, axi2array_frame_valid, wr_frame_ready, rd_frame_ready, axi2array_frame_data);
        end
        do_reset();
        prio = 2'd0;
        add_burst(1'b1, 1, 1'b1);
        add_burst(1'b0, 1, 1'b1);
        model_run();
        drain(40);
        vectors++;
        if (obs_d.size() != exp_d.size()) begin errors++; $display("FAIL mid_count got %0d frames want %0d", obs_d.size(), exp_d.size()); end
        foreach (exp_d[i]) if (i < obs_d.size()) begin
            vectors++;
            if (obs_g[i] !== exp_g[i] || obs_d[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL mid_frame%0d got gnt=%b data=%h want gnt=%b data=%h", i, obs_g[i], obs_d[i], exp_g[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_mc_en();
        do_reset();
        prio = 2'd0;
        add_burst(1'b1, 3, 1'b1);
        add_burst(1'b1, 1, 1'b1);
        add_burst(1'b0, 1, 1'b1);
        model_run();
        step();
        step();
        mc_en = 1'b0;
        repeat (11) step();
        vectors++;
        if (obs_d.size() != 3) begin errors++; $display("FAIL en_burst got %0d frames want 3", obs_d.size()); end
        for (int c = 4; c <= 12; c++) begin
            vectors++;
            if (gnt_hist[c] !== 2'b00) begin errors++; $display("FAIL en_hold cyc=%0d got gnt=%b want 00", c, gnt_hist[c]); end
        end
        mc_en = 1'b1;
        drain(40);
        vectors++;
        if (obs_d.size() != exp_d.size()) begin errors++; $display("FAIL en_count got %0d frames want %0d", obs_d.size(), exp_d.size()); end
        foreach (exp_d[i]) if (i < obs_d.size()) begin
            vectors++;
            if (obs_g[i] !== exp_g[i] || obs_d[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL en_frame%0d got gnt=%b data=%h want gnt=%b data=%h", i, obs_g[i], obs_d[i], exp_g[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_starve();
        int n_rd = 0;
        do_reset();
        prio = 2'd1;
        for (int k = 0; k < 10; k++) begin
            add_burst(1'b1, 1, 1'b1);
            add_burst(1'b0, 1, 1'b1);
        end
        model_run();
        drain(200);
        for (int i = 0; i < 10 && i < obs_g.size(); i++) if (obs_g[i] == 2'b10) n_rd++;
        vectors++;
        if (n_rd != (GUARD ? 2 : 0)) begin errors++; $display("FAIL starve_reads got %0d reads in first 10 want %0d", n_rd, GUARD ? 2 : 0); end
        vectors++;
        if (obs_d.size() != exp_d.size()) begin errors++; $display("FAIL starve_count got %0d frames want %0d", obs_d.size(), exp_d.size()); end
        foreach (exp_d[i]) if (i < obs_d.size()) begin
            vectors++;
            if (obs_g[i] !== exp_g[i] || obs_d[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL starve_frame%0d got gnt=%b data=%h want gnt=%b data=%h", i, obs_g[i], obs_d[i], exp_g[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            do_reset();
            prio = 2'($urandom_range(0, 3));
            rdy_pct = 60;
            repeat ($urandom_range(0, 4)) add_burst(1'b1, $urandom_range(1, 4), $urandom_range(0, 3) != 0);
            repeat ($urandom_range(0, 4)) add_burst(1'b0, $urandom_range(1, 4), $urandom_range(0, 3) != 0);
            model_run();
            drain(1000);
            vectors++;
            if (obs_d.size() != exp_d.size()) begin errors++; $display("FAIL rand%0d_count got %0d frames want %0d", it, obs_d.size(), exp_d.size()); end
            foreach (exp_d[i]) if (i < obs_d.size()) begin
                vectors++;
                if (obs_g[i] !== exp_g[i] || obs_d[i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL rand%0d_frame%0d got gnt=%b data=%h want gnt=%b data=%h", it, i, obs_g[i], obs_d[i], exp_g[i], exp_d[i]);
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish want finish before 1000000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_first();
        test_round_robin();
        test_ready_toggle();
        test_reset_mid_burst();
        test_mc_en();
        test_starve();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
